// File: rtl/mem_responder.sv
// mem_responder: CPU memory-port responder with work RAM, ROM fetch port,
// per-region wait states and byte-lane steering.
module mem_responder #(
   parameter int unsigned RAM_AW   = 15,
   parameter logic [7:0]  RAM_PAGE = 8'h03,
   parameter int unsigned RAM_WS   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   inout  wire  [31:0] mem_data,
   input  logic [1:0]  mem_width,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic        mem_ok,
   output logic        rom_req,
   output logic [22:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        rom_valid
);

   localparam int unsigned DEPTH = 2 ** (RAM_AW - 2);
   localparam logic [3:0]  WS_CNT = 4'(RAM_WS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ROMF, S_ACK} state_t;
   typedef enum logic [1:0] {R_NONE, R_RAM, R_ROM} region_t;

   state_t      state_q, state_d;
   region_t     region_q, region_d, req_region;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  width_q, width_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rom_req_q, rom_req_d;
   logic [22:0] rom_addr_q, rom_addr_d;
   logic [31:0] rom_word_q, rom_word_d;

   logic [3:0][7:0]   ram [DEPTH];
   logic [31:0]       ram_rd_q;
   logic [RAM_AW-3:0] rd_idx, wr_idx;

   logic        req, match, we, drive;
   logic [3:0]  be;
   logic [31:0] wdata, word, rdata;

   always_comb begin
      req_region = R_NONE;
      if (mem_addr[31:24] == RAM_PAGE)
         req_region = R_RAM;
      else if (mem_addr[31:25] == 7'h04)
         req_region = R_ROM;
   end

   // Live request must still equal the latched one, or the access is withdrawn.
   assign req   = mem_read | mem_write;
   assign match = req &&
      ({mem_addr, mem_width, mem_read, mem_write} ==
       {addr_q, width_q, rd_q, wr_q});

   always_comb begin
      state_d    = state_q;
      region_d   = region_q;
      addr_d     = addr_q;
      width_d    = width_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      cnt_d      = cnt_q;
      rom_addr_d = rom_addr_q;
      rom_word_d = rom_word_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d   = mem_addr;
               width_d  = mem_width;
               rd_d     = mem_read;
               wr_d     = mem_write;
               region_d = req_region;
               if (mem_width == 2'd3 || req_region == R_NONE ||
                   (req_region == R_ROM && mem_write)) begin
                  state_d = S_ACK;
               end else if (req_region == R_RAM) begin
                  if (WS_CNT == 4'd0) begin
                     state_d = S_ACK;
                  end else begin
                     state_d = S_WAIT;
                     cnt_d   = WS_CNT;
                  end
               end else begin
                  state_d    = S_ROMF;
                  rom_addr_d = mem_addr[24:2];
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (!match) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == 4'd1) begin
               state_d = S_ACK;
            end
         end
         S_ROMF: begin
            if (!match) begin
               state_d = S_IDLE;
            end else if (rom_valid) begin
               rom_word_d = rom_data;
               state_d    = S_ACK;
            end
         end
         S_ACK: state_d = S_IDLE;
      endcase
      rom_req_d = (state_d == S_ROMF);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         region_q   <= R_NONE;
         addr_q     <= '0;
         width_q    <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         cnt_q      <= '0;
         rom_req_q  <= 1'b0;
         rom_addr_q <= '0;
         rom_word_q <= '0;
      end else begin
         state_q    <= state_d;
         region_q   <= region_d;
         addr_q     <= addr_d;
         width_q    <= width_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         cnt_q      <= cnt_d;
         rom_req_q  <= rom_req_d;
         rom_addr_q <= rom_addr_d;
         rom_word_q <= rom_word_d;
      end
   end

   assign mem_ok   = (state_q == S_ACK) && match;
   assign rom_req  = rom_req_q;
   assign rom_addr = rom_addr_q;

   always_comb begin
      word = '0;
      if (width_q != 2'd3) begin
         case (region_q)
            R_RAM:   word = ram_rd_q;
            R_ROM:   word = rom_word_q;
            default: word = '0;
         endcase
      end
      rdata = word;
      if (width_q == 2'd0)
         rdata = {24'b0, word[8*addr_q[1:0] +: 8]};
      else if (width_q == 2'd1)
         rdata = {16'b0, word[16*addr_q[1] +: 16]};
   end

   assign drive    = mem_ok && rd_q && !wr_q;
   assign mem_data = drive ? rdata : 32'bz;

   always_comb begin
      be    = 4'b1111;
      wdata = mem_data;
      case (width_q)
         2'd0: begin
            be    = 4'b0001 << addr_q[1:0];
            wdata = {4{mem_data[7:0]}};
         end
         2'd1: begin
            be    = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata = {2{mem_data[15:0]}};
         end
         default: ;
      endcase
   end

   assign we = mem_ok && wr_q && (region_q == R_RAM) &&
               (width_q != 2'd3) && !rst;

   // Read port follows the live address in IDLE so zero-wait reads are ready at ACK.
   assign rd_idx = (state_q == S_IDLE) ? mem_addr[RAM_AW-1:2]
                                       : addr_q[RAM_AW-1:2];
   assign wr_idx = addr_q[RAM_AW-1:2];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i])
               ram[wr_idx][i] <= wdata[8*i +: 8];
         end
      end
      ram_rd_q <= ram[rd_idx];
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Bus responder for the CPU memory port: it services the `mem_addr`/`mem_data`/`mem_width`/`mem_read`/`mem_write`/`mem_ok` handshake that the CPU core initiates. It decodes the address into an internal work RAM, an external ROM read port, or unmapped space. It applies per-region wait states and byte-lane steering, and acknowledges each access with a single-cycle `mem_ok`. It sits between the CPU core and the memory resources at the top level.

## Interface
- `RAM_AW`, 15: RAM byte-address width (32 KiB), mirrored across its page.
- `RAM_PAGE`, 8'h03: `mem_addr[31:24]` value selecting RAM.
- `RAM_WS`, 0: extra RAM wait cycles (0–15).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `mem_addr`  in  32  byte address from CPU (CPU side declares inout; responder only reads).
- `mem_data`  inout  32  write data from CPU; read data driven by responder only in ACK of a read, else Z.
- `mem_width`  in  2  0 byte, 1 halfword, 2 word, 3 reserved.
- `mem_read`  in  1  read request, held by CPU until `mem_ok`.
- `mem_write`  in  1  write request, held by CPU until `mem_ok`.
- `mem_ok`  out  1  access complete this cycle.
- `rom_req`  out  1  ROM word fetch request.
- `rom_addr`  out  23  ROM word address (`mem_addr[24:2]`).
- `rom_data`  in  32  ROM word.
- `rom_valid`  in  1  `rom_data` valid; sampled only while `rom_req`=1.

## Operation
- Request present = `mem_read | mem_write`. If both are high, the request is a write and `mem_data` is never driven.
- Decode on `mem_addr[31:24]`:
  - `RAM_PAGE` → RAM. Index is `mem_addr[RAM_AW-1:0]`, storage is four byte lanes.
  - 8'h08/8'h09 → ROM.
  - Anything else → unmapped.
- Alignment: word accesses ignore `addr[1:0]`; halfword accesses ignore `addr[0]`. No rotation is applied; rotation is the CPU's job.
- Read data is the selected lane shifted to bit 0 and zero-extended:
  - byte: `{24'b0, word[8*addr[1:0]+:8]}`
  - half: `{16'b0, word[16*addr[1]+:16]}`
- Write data is taken from the low bits of `mem_data` (byte [7:0], half [15:0]) and placed into the addressed lanes. Other lanes are untouched.
- States:
  - IDLE: `mem_ok`=0. On a request, latch {addr, width, read, write} and the region, then:
    - RAM with `RAM_WS`=0 → ACK.
    - RAM with `RAM_WS`>0 → WAIT, counter = `RAM_WS`.
    - ROM read → ROMF.
    - ROM write, unmapped, or width 3 → ACK.
  - WAIT: decrement the counter each cycle; go to ACK when it reaches 1.
  - ROMF: `rom_req`=1 and `rom_addr` stable. On `rom_valid`, latch `rom_data` and go to ACK.
  - ACK: `mem_ok`=1 and the access takes effect:
    - RAM write commits at the clock edge ending this cycle.
    - Read drives `mem_data`.
    - Then go to IDLE.
- Abort: in WAIT, ROMF or ACK, compare the live {`mem_addr`, `mem_width`, `mem_read`, `mem_write`} against the latched values. On any mismatch or a dropped request:
  - `mem_ok`=0, nothing commits, `mem_data` is Z.
  - `rom_req` drops next cycle, and any late `rom_valid` is ignored.
  - Next state is IDLE. The ROM side must treat a dropped `rom_req` as a cancel.
- ROM writes, unmapped writes and width-3 writes are acknowledged and discarded.
- Unmapped reads and width-3 reads return 0.

## Timing
- Reset values: `mem_ok`=0, `rom_req`=0, `rom_addr`=0, `mem_data`=Z, state IDLE, counter 0.
- RAM contents are not reset.
- `rst` in any state: `rst` has priority over the next-state logic. No write commits in that cycle, and the block is in IDLE next cycle.
- `mem_ok` is a combinational AND of (state==ACK) and the request-match check, so it is never asserted for a withdrawn request.
- Latency, counting the request's first cycle in IDLE as cycle 0:
  - RAM: `mem_ok` in cycle `RAM_WS`+1.
  - ROM: `mem_ok` one cycle after `rom_valid` is sampled.
  - ROM write / unmapped: `mem_ok` in cycle 1.
- RAM read is synchronous. The array is read at the latched address in the cycle before ACK.
- A read after a write to the same address returns the new data.
- Back-to-back: after ACK the block returns to IDLE, so the minimum issue period is 2 cycles per access.

## Test plan
- Write word 0xDEADBEEF to 0x03000010 with `RAM_WS`=0 → `mem_ok` in cycle 1. Word read of 0x03000010 → `mem_data`=0xDEADBEEF while `mem_ok`=1.
- After test 1, byte write 0xAB to 0x03000013, then:
  - word read of 0x03000010 → 0xABADBEEF
  - half read of 0x03000012 → 0x0000ABAD
  - byte read of 0x03000011 → 0x000000BE
- `RAM_WS`=2, read 0x03000000:
  - Held → `mem_ok` only in cycle 3.
  - Repeat with `mem_read` dropped in cycle 2 → no `mem_ok`, IDLE in cycle 3.
  - Repeat with `mem_addr` changed mid-wait → restart; `mem_ok` three cycles after re-sample.
- ROM read of 0x08000104:
  - `rom_req`=1 from cycle 1 with `rom_addr`=0x41; `rom_valid` arrives 3 cycles later with 0x12345678 → `mem_ok` the next cycle with 0x12345678.
  - Byte read of 0x08000106 → 0x00000034.
- Unmapped and ROM-write accesses:
  - Write to 0x08000000 → `mem_ok` in cycle 1, `rom_req` never asserted.
  - Read of 0x05000000 → `mem_ok` in cycle 1 with data 0x00000000.
  - RAM unchanged.
- `rst` pulsed during WAIT of a RAM write with `RAM_WS`=3 → no `mem_ok`, target word unchanged on readback, `mem_data`=Z, `rom_req`=0.
